// File: rtl/inst_fetch_cache.sv
// inst_fetch_cache: direct-mapped, read-only instruction cache with multi-word
// lines, placed directly after the PC register. Cached misses refill a whole
// line over a burst read port. Addresses in the kseg1 window
// (addr[31:29] == 3'b101) are always fetched uncached with a single beat.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   cpu_req, cpu_addr  fetch request and fetch address (PC); bits [1:0] ignored
//   cpu_rdata          instruction word, valid when cpu_req && !cpu_stall
//   cpu_stall          fetch not complete; PC must hold
//   mem_req, mem_addr, mem_len   registered burst read request (len = beats-1)
//   mem_addr_ok        memory accepted the request
//   mem_rdata, mem_rvalid, mem_rlast   read beat stream
module inst_fetch_cache #(
    parameter int unsigned INDEX_WIDTH  = 6,
    parameter int unsigned OFFSET_WIDTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [1:0]  mem_len,
    input  logic        mem_addr_ok,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    input  logic        mem_rlast
);

    localparam int unsigned LINES     = 1 << INDEX_WIDTH;
    localparam int unsigned WORDS     = 1 << OFFSET_WIDTH;
    localparam int unsigned TAG_LSB   = INDEX_WIDTH + OFFSET_WIDTH + 2;
    localparam int unsigned TAG_WIDTH = 32 - TAG_LSB;
    localparam logic [31:0] LINE_MASK = 32'(WORDS * 4 - 1);

    typedef enum logic [1:0] {IDLE, REQ, RECV, DONE} state_t;

    state_t state, state_next;

    logic [LINES-1:0]     valid;
    logic [TAG_WIDTH-1:0] tags [LINES];
    logic [31:0]          data [LINES][WORDS];

    logic [OFFSET_WIDTH-1:0] beat_cnt;
    logic [31:0]             unc_buf;

    // Snapshot of the missing fetch, so the refill and DONE do not depend on
    // the CPU keeping cpu_addr stable beyond the stall.
    logic                    fill_unc;
    logic [INDEX_WIDTH-1:0]  fill_index;
    logic [TAG_WIDTH-1:0]    fill_tag;
    logic [OFFSET_WIDTH-1:0] fill_offset;

    logic [TAG_WIDTH-1:0]    addr_tag;
    logic [INDEX_WIDTH-1:0]  addr_index;
    logic [OFFSET_WIDTH-1:0] addr_offset;
    logic                    addr_unc;
    logic                    hit;

    assign addr_tag    = cpu_addr[31:TAG_LSB];
    assign addr_index  = cpu_addr[TAG_LSB-1 -: INDEX_WIDTH];
    assign addr_offset = cpu_addr[OFFSET_WIDTH+1 -: OFFSET_WIDTH];
    assign addr_unc    = (cpu_addr[31:29] == 3'b101);
    assign hit         = !addr_unc && valid[addr_index] && (tags[addr_index] == addr_tag);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        cpu_stall  = 1'b0;
        cpu_rdata  = '0;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    if (hit) begin
                        cpu_rdata = data[addr_index][addr_offset];
                    end else begin
                        cpu_stall  = 1'b1;
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                cpu_stall = 1'b1;
                if (mem_addr_ok) state_next = RECV;
            end
            RECV: begin
                cpu_stall = 1'b1;
                if (mem_rvalid && mem_rlast) state_next = DONE;
            end
            DONE: begin
                cpu_rdata  = fill_unc ? unc_buf : data[fill_index][fill_offset];
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Control and request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid       <= '0;
            beat_cnt    <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            mem_len     <= '0;
            unc_buf     <= '0;
            fill_unc    <= 1'b0;
            fill_index  <= '0;
            fill_tag    <= '0;
            fill_offset <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req && !hit) begin
                        mem_req     <= 1'b1;
                        fill_unc    <= addr_unc;
                        fill_index  <= addr_index;
                        fill_tag    <= addr_tag;
                        fill_offset <= addr_offset;
                        if (addr_unc) begin
                            mem_addr <= cpu_addr & ~32'h3;
                            mem_len  <= 2'd0;
                        end else begin
                            mem_addr <= cpu_addr & ~LINE_MASK;
                            mem_len  <= 2'(WORDS - 1);
                            // The line is overwritten in place, so it must stop
                            // hitting now in case the refill is later aborted.
                            valid[addr_index] <= 1'b0;
                        end
                    end
                end
                REQ: begin
                    if (mem_addr_ok) begin
                        mem_req  <= 1'b0;
                        beat_cnt <= '0;
                    end
                end
                RECV: begin
                    if (mem_rvalid) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (fill_unc) unc_buf <= mem_rdata;
                        if (mem_rlast && !fill_unc) valid[fill_index] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays carry no reset; writes are suppressed while rst is high.
    always_ff @(posedge clk) begin
        if (!rst && state == RECV && mem_rvalid && !fill_unc) begin
            data[fill_index][beat_cnt] <= mem_rdata;
            if (mem_rlast) tags[fill_index] <= fill_tag;
        end
    end

    // A cached burst that runs past the end of the line wraps the beat counter.
    a_burst_overrun: assert property (@(posedge clk) disable iff (rst)
        !(state == RECV && mem_rvalid && !mem_rlast && !fill_unc && beat_cnt == '1));

endmodule

// File: tb/tb_inst_fetch_cache.sv
// Directed bench for inst_fetch_cache: uncached fetches, line refills, hits,
// conflict replacement, gapped beats and reset during a refill. Expected words
// are queued when a fetch is issued and popped when the fetch completes.
module tb_inst_fetch_cache;

    typedef logic [31:0] beats_t [4];

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [1:0]  mem_len;
    logic        mem_addr_ok;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        mem_rlast;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] exp_q [$];

    inst_fetch_cache #(.INDEX_WIDTH(6), .OFFSET_WIDTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_len    (mem_len),
        .mem_addr_ok(mem_addr_ok),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .mem_rlast  (mem_rlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pop the scoreboard and compare against the word the DUT returns now.
    task automatic check_word(input string tag);
        logic [31:0] exp;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: observed %h expected <scoreboard empty>", tag, cpu_rdata);
        end else begin
            exp = exp_q.pop_front();
            check(tag, cpu_rdata, exp);
        end
    endtask

    task automatic hit_fetch(input logic [31:0] addr, input logic [31:0] word);
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = addr;
        exp_q.push_back(word);
        #1;
        check("hit_stall", 32'(cpu_stall), 32'd0);
        check("hit_memreq", 32'(mem_req), 32'd0);
        check_word("hit_rdata");
        cpu_req = 1'b0;
    endtask

    task automatic miss_fetch(input logic [31:0] addr, input logic [31:0] exp_maddr,
                              input logic [1:0] exp_len, input int unsigned ok_delay,
                              input bit gap, input int unsigned nbeats,
                              input beats_t beats, input logic [31:0] word);
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = addr;
        exp_q.push_back(word);
        #1;
        check("miss_stall", 32'(cpu_stall), 32'd1);
        check("miss_memreq_reg", 32'(mem_req), 32'd0);
        @(negedge clk);
        check("req_memreq", 32'(mem_req), 32'd1);
        check("req_addr", mem_addr, exp_maddr);
        check("req_len", 32'(mem_len), 32'(exp_len));
        for (int i = 0; i < int'(ok_delay); i++) begin
            @(negedge clk);
            check("req_hold", 32'(mem_req), 32'd1);
            check("req_hold_addr", mem_addr, exp_maddr);
            check("req_hold_stall", 32'(cpu_stall), 32'd1);
        end
        mem_addr_ok = 1'b1;
        @(negedge clk);
        mem_addr_ok = 1'b0;
        #1;
        check("recv_memreq_drop", 32'(mem_req), 32'd0);
        for (int i = 0; i < int'(nbeats); i++) begin
            if (gap && i > 0) begin
                mem_rvalid = 1'b0;
                @(negedge clk);
                #1;
                check("gap_stall", 32'(cpu_stall), 32'd1);
            end
            mem_rvalid = 1'b1;
            mem_rdata  = beats[i];
            mem_rlast  = (i == int'(nbeats) - 1);
            @(negedge clk);
            #1;
            if (i != int'(nbeats) - 1) check("recv_stall", 32'(cpu_stall), 32'd1);
        end
        mem_rvalid = 1'b0;
        mem_rlast  = 1'b0;
        mem_rdata  = 32'hdead_beef;
        check("done_stall", 32'(cpu_stall), 32'd0);
        check_word("done_rdata");
        cpu_req = 1'b0;
    endtask

    beats_t ba, bb, bc, bd, bu;

    initial begin
        rst         = 1'b1;
        cpu_req     = 1'b0;
        cpu_addr    = '0;
        mem_addr_ok = 1'b0;
        mem_rdata   = '0;
        mem_rvalid  = 1'b0;
        mem_rlast   = 1'b0;
        ba = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
        bb = '{32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003};
        bc = '{32'hC000_0000, 32'hC000_0001, 32'hC000_0002, 32'hC000_0003};
        bd = '{32'hD000_0000, 32'hD000_0001, 32'hD000_0002, 32'hD000_0003};
        bu = '{32'h3c1d_bfc0, 32'h0, 32'h0, 32'h0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_stall", 32'(cpu_stall), 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        check("rst_memreq", 32'(mem_req), 32'd0);
        check("rst_memaddr", mem_addr, 32'd0);
        check("rst_memlen", 32'(mem_len), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_noreq_stall", 32'(cpu_stall), 32'd0);
            check("idle_noreq_rdata", cpu_rdata, 32'd0);
            check("idle_noreq_memreq", 32'(mem_req), 32'd0);
        end

        // Uncached reset vector, then the same address misses again.
        miss_fetch(32'hbfc0_0000, 32'hbfc0_0000, 2'd0, 0, 1'b0, 1, bu, 32'h3c1d_bfc0);
        bu[0] = 32'h2400_0001;
        miss_fetch(32'hbfc0_0000, 32'hbfc0_0000, 2'd0, 1, 1'b0, 1, bu, 32'h2400_0001);
        // Uncached mid-word address: byte bits dropped only.
        bu[0] = 32'h2400_0002;
        miss_fetch(32'hbfc0_0016, 32'hbfc0_0014, 2'd0, 0, 1'b0, 1, bu, 32'h2400_0002);

        // Cached line refill, requested word at offset 1, delayed accept.
        miss_fetch(32'h8000_0014, 32'h8000_0010, 2'd3, 2, 1'b0, 4, ba, 32'hA000_0001);
        hit_fetch(32'h8000_0010, 32'hA000_0000);
        hit_fetch(32'h8000_0018, 32'hA000_0002);
        hit_fetch(32'h8000_001c, 32'hA000_0003);
        hit_fetch(32'h8000_0014, 32'hA000_0001);

        // Beats with idle gaps between them.
        miss_fetch(32'h8000_0024, 32'h8000_0020, 2'd3, 1, 1'b1, 4, bb, 32'hB000_0001);
        hit_fetch(32'h8000_0020, 32'hB000_0000);
        hit_fetch(32'h8000_0028, 32'hB000_0002);
        hit_fetch(32'h8000_002c, 32'hB000_0003);

        // Conflict: same index, different tag replaces the line.
        miss_fetch(32'h8000_0410, 32'h8000_0410, 2'd3, 0, 1'b0, 4, bc, 32'hC000_0000);
        hit_fetch(32'h8000_0414, 32'hC000_0001);
        miss_fetch(32'h8000_0010, 32'h8000_0010, 2'd3, 0, 1'b0, 4, ba, 32'hA000_0000);
        hit_fetch(32'h8000_001c, 32'hA000_0003);
        hit_fetch(32'h8000_0024, 32'hB000_0001);

        // Reset during the second beat of a refill; trailing beats are stale.
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = 32'h8000_0108;
        @(negedge clk);
        mem_addr_ok = 1'b1;
        @(negedge clk);
        mem_addr_ok = 1'b0;
        mem_rvalid  = 1'b1;
        mem_rdata   = 32'h5555_0000;
        @(negedge clk);
        mem_rdata = 32'h5555_0001;
        rst       = 1'b1;
        cpu_req   = 1'b0;
        @(negedge clk);
        rst       = 1'b0;
        mem_rdata = 32'h5555_0002;
        #1;
        check("abort_memreq", 32'(mem_req), 32'd0);
        check("abort_stall", 32'(cpu_stall), 32'd0);
        check("abort_rdata", cpu_rdata, 32'd0);
        @(negedge clk);
        mem_rdata = 32'h5555_0003;
        mem_rlast = 1'b1;
        #1;
        check("stale_stall", 32'(cpu_stall), 32'd0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rlast  = 1'b0;
        #1;
        check("stale_memreq", 32'(mem_req), 32'd0);
        check("stale_stall2", 32'(cpu_stall), 32'd0);
        miss_fetch(32'h8000_0108, 32'h8000_0100, 2'd3, 0, 1'b0, 4, bd, 32'hD000_0002);
        hit_fetch(32'h8000_0104, 32'hD000_0001);
        // Reset cleared every valid bit, so an earlier line misses again.
        miss_fetch(32'h8000_0018, 32'h8000_0010, 2'd3, 0, 1'b0, 4, ba, 32'hA000_0002);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch_cache.md
Name: inst_fetch_cache

Overview:
Direct-mapped instruction cache with multi-word lines. It sits directly downstream of the PC register: it takes the PC value as the fetch address, returns the instruction word, and raises a stall that the core feeds back to the PC enable (en = ~cpu_stall). Misses refill a whole line over a burst read interface. The kseg1 window (addr[31:29]==3'b101, including the 32'hbfc00000 reset vector) is fetched uncached.

Parameters:
INDEX_WIDTH, 6, line index bits; the cache holds 2^INDEX_WIDTH lines.
OFFSET_WIDTH, 2, word-offset bits; a line holds 2^OFFSET_WIDTH 32-bit words (4 by default).

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  synchronous active-high reset.
cpu_req  in  1  fetch request this cycle.
cpu_addr  in  32  fetch address (PC). Bits [1:0] are ignored. Held stable while cpu_stall=1.
cpu_rdata  out  32  instruction word. Valid when cpu_req=1 and cpu_stall=0.
cpu_stall  out  1  fetch not complete; the PC must hold.
mem_req  out  1  burst read request.
mem_addr  out  32  burst start address.
mem_len  out  2  number of beats minus 1: 3 for a line refill, 0 for an uncached fetch.
mem_addr_ok  in  1  memory accepted the request this cycle.
mem_rdata  in  32  read beat data.
mem_rvalid  in  1  beat valid.
mem_rlast  in  1  final beat of the burst.

Behaviour:
- Address split: tag = addr[31:INDEX_WIDTH+OFFSET_WIDTH+2], index = next INDEX_WIDTH bits, word offset = next OFFSET_WIDTH bits.
- Storage: per line a valid bit, a tag, and data words, all in flops/distributed registers.
- States and transitions:
  - IDLE:
    - Hit (cached address, valid[index] set and tag matches): cpu_rdata = line word, combinational, same cycle; cpu_stall=0.
    - Cached miss: cpu_stall=1; go to REQ, with mem_addr = addr with offset and byte bits zeroed, mem_len=3.
    - Uncached address: always a miss; go to REQ, with mem_addr = addr & ~3, mem_len=0.
  - REQ: mem_req=1, and mem_addr/mem_len held stable, until mem_addr_ok=1. Then go to RECV, clear the beat counter, and drop mem_req the next cycle.
  - RECV:
    - Each mem_rvalid beat is written to word[beat counter] of the target line (cached case) or to the uncached buffer; the counter then increments.
    - Ignore mem_rvalid in every other state.
    - On a beat with mem_rlast=1: for a cached fetch, set valid[index] and tag[index]; go to DONE.
  - DONE: one cycle with cpu_stall=0. cpu_rdata = the requested word (line word at the offset, or the uncached buffer). Return to IDLE.
- cpu_stall = (state==IDLE && cpu_req && !hit) || state==REQ || state==RECV.
- No request: when cpu_req=0 in IDLE, cpu_stall=0 and cpu_rdata=0.
- Line update: the line is written in place during RECV. valid is set only on the last beat, so a partial line is never reported as a hit.
- Reset values (synchronous, checked at the clock edge):
  - state=IDLE, every valid bit=0, beat counter=0, mem_req=0, mem_addr=0, mem_len=0, uncached buffer=0.
  - With cpu_req=0, cpu_stall=0 and cpu_rdata=0.
  - Tag and data arrays need not reset.
- rst during REQ or RECV: abort the refill and return to IDLE. The line stays invalid. Any later beats from memory are ignored while in IDLE/DONE. Memory is required to tolerate an abandoned burst.
- mem_addr_ok in the same cycle as entering REQ cannot occur, because mem_req is registered. The first cycle mem_req can be seen high is the cycle after the miss.
- Beat count: mem_rlast is trusted. If more than 2^OFFSET_WIDTH beats arrive, the counter wraps; this is flagged as a protocol error in simulation only.
- Replacement: a miss to a valid line with a different tag overwrites it; there is no write-back (read-only cache).

Test Plan:
- Reset, then cpu_req=1, cpu_addr=32'hbfc00000 -> uncached.
  - Stall asserts.
  - mem_req=1 with mem_addr=32'hbfc00000, mem_len=0.
  - After ok plus one beat of 32'h3c1dbfc0 with rlast, DONE shows rdata=32'h3c1dbfc0 and stall=0.
  - A repeat fetch of the same address misses again.
- Cached miss at 32'h80000014.
  - mem_addr=32'h80000010, mem_len=3.
  - Beats A0..A3 (mem_addr_ok delayed 2 cycles) lead to DONE with rdata=A1.
  - Fetches of 32'h80000010, 32'h80000018 and 32'h8000001c then hit in 0 stall cycles, returning A0, A2 and A3.
- Conflict: after the line for 32'h80000010 is filled, fetch 32'h80000410, which has the same index and a different tag -> miss and refill. A subsequent fetch of 32'h80000010 misses.
- Beats with gaps (rvalid low between beats): data lands at the correct offsets and stall stays high until DONE.
- rst asserted during the 2nd beat of a refill -> next cycle state=IDLE, mem_req=0. The refetch of the same address misses (valid=0), and the stale beats that follow are ignored.
- cpu_req=0 after reset -> stall=0, rdata=0, mem_req stays 0.
